// File: rtl/scoreboard_insert_ctrl_pkg.sv
// scoreboard_insert_ctrl_pkg
// Shared sizes, entry layout and FSM encoding.
package scoreboard_insert_ctrl_pkg;

    localparam int SB_ALPHABET_SIZE = 5;
    localparam int SB_SCORE_SIZE    = 16;
    localparam int SB_DEPTH         = 8;
    localparam int SB_NAME_W        = 3 * SB_ALPHABET_SIZE;
    // An entry is {score, name}; score occupies the upper bits.
    localparam int SB_ENTRY_W       = SB_SCORE_SIZE + SB_NAME_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WALK,
        S_DONE
    } state_t;

endpackage

// File: rtl/scoreboard_insert_ctrl_table.sv
// scoreboard_table
// Sorted entry registers: async reads, shift-down and slot write.
module scoreboard_table
    import scoreboard_insert_ctrl_pkg::*;
#(
    parameter int EW    = SB_ENTRY_W,
    parameter int SW    = SB_SCORE_SIZE,
    parameter int DEPTH = SB_DEPTH,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          shift_en,
    input  logic [IW-1:0] shift_idx,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [EW-1:0] wr_data,
    input  logic [IW-1:0] rd_idx,
    output logic [EW-1:0] rd_data,
    input  logic [IW-1:0] cmp_idx,
    output logic [SW-1:0] cmp_score
);

    logic [EW-1:0] mem [DEPTH];

    assign rd_data   = mem[rd_idx];
    assign cmp_score = mem[cmp_idx][EW-1 -: SW];

    // Slot write wins over shift; shift copies slot k-1 into slot k.
    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (rst) begin
                mem[k] <= '0;
            end else if (wr_en && wr_idx == IW'(k)) begin
                mem[k] <= wr_data;
            end else if (shift_en && k > 0 &&
                         shift_idx == IW'(k - 1)) begin
                mem[k] <= mem[(k > 0) ? k - 1 : 0];
            end
        end
    end

endmodule

// File: rtl/scoreboard_insert_ctrl.sv
// scoreboard_insert_ctrl
// Walks one new entry up the sorted high-score table.
module scoreboard_insert_ctrl
    import scoreboard_insert_ctrl_pkg::*;
#(
    parameter int ALPHABET_SIZE = SB_ALPHABET_SIZE,
    parameter int SCORE_SIZE    = SB_SCORE_SIZE,
    parameter int DEPTH         = SB_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       insert_valid,
    output logic                       insert_ready,
    input  logic [SCORE_SIZE-1:0]      insert_score,
    input  logic [3*ALPHABET_SIZE-1:0] insert_name,
    input  logic [$clog2(DEPTH)-1:0]   rd_index,
    output logic [SCORE_SIZE-1:0]      rd_score,
    output logic [3*ALPHABET_SIZE-1:0] rd_name,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     rank
);

    localparam int NW = 3 * ALPHABET_SIZE;
    localparam int EW = SCORE_SIZE + NW;
    localparam int IW = $clog2(DEPTH);
    localparam int RW = IW + 1;
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

    state_t                state;
    logic [IW-1:0]         idx;
    logic [EW-1:0]         held;
    logic [SCORE_SIZE-1:0] cur_score;
    logic [EW-1:0]         rd_data;
    logic                  win;
    logic                  shift_en;
    logic                  wr_en;
    logic [IW-1:0]         wr_idx;

    assign win      = held[EW-1 -: SCORE_SIZE] > cur_score;
    assign rd_score = rd_data[EW-1 -: SCORE_SIZE];
    assign rd_name  = rd_data[NW-1:0];

    // Table write decode for the current WALK step.
    always_comb begin
        shift_en = 1'b0;
        wr_en    = 1'b0;
        wr_idx   = '0;
        if (state == S_WALK) begin
            unique case (1'b1)
                win: begin
                    shift_en = (idx != LAST);
                    wr_en    = (idx == '0);
                end
                default: begin
                    wr_en  = (idx != LAST);
                    wr_idx = idx + IW'(1);
                end
            endcase
        end
    end

    // Controller FSM, index, holding register and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            held         <= '0;
            rank         <= RW'(DEPTH);
            insert_ready <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (insert_valid && insert_ready) begin
                        held         <= {insert_score, insert_name};
                        idx          <= LAST;
                        state        <= S_WALK;
                        insert_ready <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                S_WALK: begin
                    if (win && idx != '0) begin
                        idx <= idx - IW'(1);
                    end else begin
                        // idx+1 == DEPTH when nothing was beaten.
                        rank  <= win ? '0 : RW'(idx) + RW'(1);
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state        <= S_IDLE;
                    busy         <= 1'b0;
                    insert_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    scoreboard_table #(
        .EW    (EW),
        .SW    (SCORE_SIZE),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_table (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (shift_en),
        .shift_idx (idx),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (held),
        .rd_idx    (rd_index),
        .rd_data   (rd_data),
        .cmp_idx   (idx),
        .cmp_score (cur_score)
    );

endmodule

// File: tb/tb_scoreboard_insert_ctrl.sv
// tb_scoreboard_insert_ctrl
// Directed and random inserts against a sorted-list model.
module tb_scoreboard_insert_ctrl;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        insert_valid;
    logic        insert_ready;
    logic [15:0] insert_score;
    logic [14:0] insert_name;
    logic [2:0]  rd_index;
    logic [15:0] rd_score;
    logic [14:0] rd_name;
    logic        busy;
    logic        done;
    logic [3:0]  rank;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_score [D];
    logic [14:0] m_name  [D];

    always #5 clk = ~clk;

    scoreboard_insert_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .insert_valid (insert_valid),
        .insert_ready (insert_ready),
        .insert_score (insert_score),
        .insert_name  (insert_name),
        .rd_index     (rd_index),
        .rd_score     (rd_score),
        .rd_name      (rd_name),
        .busy         (busy),
        .done         (done),
        .rank         (rank)
    );

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] nm(input int a, b, c);
        return {5'(a), 5'(b), 5'(c)};
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < D; k++) begin
            m_score[k] = '0;
            m_name[k]  = '0;
        end
    endfunction

    // Position = number of entries scoring at least s.
    function automatic int model_insert(input logic [15:0] s,
                                        input logic [14:0] n);
        int pos = 0;
        while (pos < D && m_score[pos] >= s) pos++;
        if (pos < D) begin
            for (int k = D - 1; k > pos; k--) begin
                m_score[k] = m_score[k-1];
                m_name[k]  = m_name[k-1];
            end
            m_score[pos] = s;
            m_name[pos]  = n;
        end
        return pos;
    endfunction

    function automatic int exp_walk(input int pos);
        if (pos == 0) return D;
        if (pos < D) return D - pos + 1;
        return 1;
    endfunction

    task automatic check_table(input string tag);
        for (int k = 0; k < D; k++) begin
            rd_index = 3'(k);
            #1;
            chk($sformatf("%s_score%0d", tag, k),
                64'(rd_score), 64'(m_score[k]));
            chk($sformatf("%s_name%0d", tag, k),
                64'(rd_name), 64'(m_name[k]));
        end
    endtask

    task automatic accept(input logic [15:0] s,
                          input logic [14:0] n);
        int c = 0;
        while (!insert_ready && c < 30) begin
            @(negedge clk);
            c++;
        end
        chk("accept_ready", 64'(insert_ready), 64'(1));
        insert_valid = 1'b1;
        insert_score = s;
        insert_name  = n;
        @(posedge clk);
        #1 insert_valid = 1'b0;
    endtask

    task automatic wait_done(output int w, output bit ok);
        int c = 0;
        w  = 0;
        ok = 1'b0;
        while (!ok && c < 30) begin
            @(negedge clk);
            c++;
            if (done) ok = 1'b1;
            else if (busy) w++;
        end
    endtask

    task automatic run_insert(input logic [15:0] s,
                              input logic [14:0] n,
                              input string tag);
        int  pos;
        int  w;
        bit  ok;
        accept(s, n);
        pos = model_insert(s, n);
        wait_done(w, ok);
        chk({tag, "_done_seen"}, 64'(ok), 64'(1));
        if (ok) begin
            chk({tag, "_rank"}, 64'(rank), 64'(pos));
            chk({tag, "_walk"}, 64'(w), 64'(exp_walk(pos)));
        end
        check_table(tag);
        @(negedge clk);
        chk({tag, "_idle_ready"}, 64'(insert_ready), 64'(1));
        chk({tag, "_idle_busy"}, 64'(busy), 64'(0));
        chk({tag, "_idle_done"}, 64'(done), 64'(0));
    endtask

    initial begin
        int  pa, pb, w, hi, nd;
        bit  ok;
        logic [15:0] rs;

        rst          = 1'b1;
        insert_valid = 1'b0;
        insert_score = '0;
        insert_name  = '0;
        rd_index     = '0;
        model_clear();

        // Reset state.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(insert_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_rank", 64'(rank), 64'(D));
        check_table("rst");
        @(negedge clk);

        // Single insert on empty table.
        run_insert(16'd500, nm(1, 1, 1), "aaa");

        // Fill 800..100, then mid, low and tie inserts.
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        @(negedge clk);
        for (int v = 8; v >= 1; v--)
            run_insert(16'(v * 100), nm(v, v, v), "fill");
        run_insert(16'd450, nm(2, 3, 4), "mid450");
        run_insert(16'd50, nm(5, 5, 5), "low50");
        run_insert(16'd500, nm(26, 26, 26), "tie500");

        // Valid held through a busy insert with a new entry.
        insert_valid = 1'b1;
        insert_score = 16'd650;
        insert_name  = nm(2, 15, 2);
        @(posedge clk);
        #1;
        insert_score = 16'd650;
        insert_name  = nm(3, 1, 20);
        pa = model_insert(16'd650, nm(2, 15, 2));
        hi = 0;
        ok = 1'b0;
        for (int c = 0; c < 30 && !ok; c++) begin
            @(negedge clk);
            if (insert_ready) hi++;
            if (done) ok = 1'b1;
        end
        chk("hold_a_done", 64'(ok), 64'(1));
        chk("hold_a_rank", 64'(rank), 64'(pa));
        chk("hold_no_ready_busy", 64'(hi), 64'(0));
        @(negedge clk);
        chk("hold_ready_idle", 64'(insert_ready), 64'(1));
        @(posedge clk);
        #1 insert_valid = 1'b0;
        pb = model_insert(16'd650, nm(3, 1, 20));
        wait_done(w, ok);
        chk("hold_b_done", 64'(ok), 64'(1));
        chk("hold_b_rank", 64'(rank), 64'(pb));
        chk("hold_b_walk", 64'(w), 64'(exp_walk(pb)));
        nd = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("hold_extra_done", 64'(nd), 64'(0));
        check_table("hold");
        @(negedge clk);

        // Reset during the third WALK cycle.
        accept(16'd900, nm(9, 9, 9));
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        @(negedge clk);
        chk("mid_rst_ready", 64'(insert_ready), 64'(1));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        chk("mid_rst_rank", 64'(rank), 64'(D));
        check_table("mid_rst");
        nd = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("mid_rst_no_done", 64'(nd), 64'(0));

        // Random inserts with zeros and ties.
        for (int t = 0; t < 40; t++) begin
            rs = 16'($urandom_range(0, 12) * 100);
            run_insert(rs, 15'($urandom_range(0, 32767)),
                       $sformatf("rnd%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
